// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single 16-bit-phased SRAM controller; one atomic 32-bit op per grant.
// Optional SRAM_ARB_RR_EN selects round-robin between ports; otherwise port 0 has fixed priority.
module sram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_wr_en,
    input  logic              p0_rd_en,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_done,
    output logic              p0_stall,
    input  logic              p1_wr_en,
    input  logic              p1_rd_en,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_done,
    output logic              p1_stall,
    output logic [1:0]        owner,
    output logic              sram_writeEn,
    output logic              sram_readEn,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_WriteData,
    input  logic [DATA_W-1:0] sram_ReadData,
    input  logic              sram_ready
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_port;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;

    logic              w_req0;
    logic              w_req1;
    logic              w_launch;
    logic              w_grant;
    logic              w_sel_wr;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    assign w_req0   = p0_wr_en | p0_rd_en;
    assign w_req1   = p1_wr_en | p1_rd_en;
    assign w_launch = (r_state == ST_IDLE) && (w_req0 || w_req1);

`ifdef SRAM_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (w_launch) begin
            r_last <= w_grant;
        end
    end

    // On contention the port not served last wins; a lone requester always wins.
    assign w_grant = (w_req0 && w_req1) ? ~r_last : w_req1;
`else
    assign w_grant = ~w_req0 & w_req1;
`endif

    // Write takes precedence when a port raises both wr_en and rd_en.
    assign w_sel_wr    = w_grant ? p1_wr_en : p0_wr_en;
    assign w_sel_addr  = w_grant ? p1_addr  : p0_addr;
    assign w_sel_wdata = w_grant ? p1_wdata : p0_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_port     <= 1'b0;
            r_wr       <= 1'b0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_launch) begin
                r_port <= w_grant;
                r_wr   <= w_sel_wr;
            end
            if (r_state == ST_BUSY && sram_ready && !r_wr) begin
                if (r_port) begin
                    r_p1_rdata <= sram_ReadData;
                end else begin
                    r_p0_rdata <= sram_ReadData;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
        end
    end

    always_comb begin
        w_next         = r_state;
        sram_writeEn   = 1'b0;
        sram_readEn    = 1'b0;
        sram_address   = '0;
        sram_WriteData = '0;
        owner          = 2'b00;
        p0_done        = 1'b0;
        p1_done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req0 || w_req1) begin
                    w_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // The first BUSY cycle always sees ready low, so no special case is needed.
                sram_writeEn   = r_wr;
                sram_readEn    = ~r_wr;
                sram_address   = r_addr;
                sram_WriteData = r_wdata;
                owner          = r_port ? 2'b10 : 2'b01;
                if (sram_ready) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                owner   = r_port ? 2'b10 : 2'b01;
                p0_done = ~r_port;
                p1_done = r_port;
                w_next  = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign p0_rdata = r_p0_rdata;
    assign p1_rdata = r_p1_rdata;
    assign p0_stall = w_req0 & ~p0_done;
    assign p1_stall = w_req1 & ~p1_done;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM controller model plus a grant-order/read-data scoreboard.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;
    logic        p0_wr_en, p0_rd_en, p1_wr_en, p1_rd_en;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_done, p1_done, p0_stall, p1_stall;
    logic [1:0]  owner;
    logic        sram_writeEn, sram_readEn;
    logic [31:0] sram_address, sram_WriteData, sram_ReadData;
    logic        sram_ready;

    sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .p0_wr_en(p0_wr_en), .p0_rd_en(p0_rd_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_stall(p0_stall),
        .p1_wr_en(p1_wr_en), .p1_rd_en(p1_rd_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_stall(p1_stall),
        .owner(owner),
        .sram_writeEn(sram_writeEn), .sram_readEn(sram_readEn),
        .sram_address(sram_address), .sram_WriteData(sram_WriteData),
        .sram_ReadData(sram_ReadData), .sram_ready(sram_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Controller model: phase 0 idle, writes take phases 1-2, reads 1-5; ready in the last phase.
    logic [31:0] mdl_mem [256];
    int          c_ph;
    bit          c_wr;

    always @(posedge clk) begin
        if (rst) begin
            c_ph <= 0;
        end else if (c_ph == 0) begin
            if (sram_writeEn) begin
                c_ph <= 1;
                c_wr <= 1'b1;
            end else if (sram_readEn) begin
                c_ph <= 1;
                c_wr <= 1'b0;
            end
        end else if (c_ph == (c_wr ? 2 : 5)) begin
            c_ph <= 0;
            if (c_wr) mdl_mem[sram_address[9:2]] <= sram_WriteData;
        end else begin
            c_ph <= c_ph + 1;
        end
    end

    assign sram_ready    = (c_ph != 0) && (c_ph == (c_wr ? 2 : 5));
    assign sram_ReadData = (sram_ready && !c_wr) ? mdl_mem[sram_address[9:2]] : 32'hBAD0_0BAD;

    typedef struct {
        int          port;
        bit          wr;
        logic [31:0] data;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] exp_mem [256];

    task automatic push_exp(input int port, input bit wr, input logic [31:0] a, input logic [31:0] d);
        sb_t e;
        e.port = port;
        e.wr   = wr;
        if (wr) begin
            exp_mem[a[9:2]] = d;
            e.data = d;
        end else begin
            e.data = exp_mem[a[9:2]];
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (p0_done || p1_done)) begin
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 1, 0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check_eq("sb_done_port", {62'd0, p1_done, p0_done}, (e.port == 1) ? 64'd2 : 64'd1);
                if (!e.wr) check_eq("sb_rdata", (e.port == 1) ? p1_rdata : p0_rdata, e.data);
            end
        end
    end

    function automatic logic get_done(input int port);
        return (port == 1) ? p1_done : p0_done;
    endfunction

    function automatic logic get_stall(input int port);
        return (port == 1) ? p1_stall : p0_stall;
    endfunction

    task automatic drive(input int port, input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        if (port == 1) begin
            p1_wr_en = wr; p1_rd_en = rd; p1_addr = a; p1_wdata = d;
        end else begin
            p0_wr_en = wr; p0_rd_en = rd; p0_addr = a; p0_wdata = d;
        end
    endtask

    // One isolated op with per-cycle checks of the controller-side bus and the done/stall timing.
    task automatic run_single(input int port, input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        int lat;
        lat = wr ? 4 : 7;
        @(posedge clk); #1;
        drive(port, wr, rd, a, d);
        push_exp(port, wr, a, d);
        @(negedge clk);
        check_eq("req_owner_idle", owner, 0);
        check_eq("req_stall", get_stall(port), 1);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check_eq("busy_wren", sram_writeEn, wr);
            check_eq("busy_rden", sram_readEn, !wr);
            check_eq("busy_addr", sram_address, a);
            if (wr) check_eq("busy_wdata", sram_WriteData, d);
            check_eq("busy_owner", owner, (port == 1) ? 2'b10 : 2'b01);
            check_eq("busy_done", get_done(port), 0);
        end
        @(negedge clk);
        check_eq("done_pulse", get_done(port), 1);
        check_eq("done_stall", get_stall(port), 0);
        check_eq("done_en_off", {sram_writeEn, sram_readEn}, 0);
        drive(port, 1'b0, 1'b0, a, d);
        @(negedge clk);
        check_eq("after_owner", owner, 0);
        check_eq("after_done", get_done(port), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n_done;
        int p1_cycles;
        bit got;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_owner", owner, 0);
        check_eq("rst_en", {sram_writeEn, sram_readEn}, 0);
        check_eq("rst_addr", sram_address, 0);
        check_eq("rst_done", {p1_done, p0_done}, 0);
        check_eq("rst_rdata0", p0_rdata, 0);
        check_eq("rst_rdata1", p1_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_single(0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        run_single(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        check_eq("rdata_hold", p0_rdata, 32'hDEAD_BEEF);
        run_single(1, 1'b1, 1'b0, 32'h0000_0020, 32'h1111_0000);
        run_single(0, 1'b1, 1'b0, 32'h0000_0024, 32'h2222_0001);
        run_single(1, 1'b1, 1'b0, 32'h0000_0048, 32'h4444_0004);
        run_single(0, 1'b1, 1'b1, 32'h0000_0050, 32'h6666_6666);
        run_single(1, 1'b0, 1'b1, 32'h0000_0050, 32'h0);

        // Continuous contention from a fresh reset so the round-robin pointer starts at port 1.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b1, 32'h0000_0020, 32'h0);
        drive(1, 1'b0, 1'b1, 32'h0000_0024, 32'h0);
`ifdef SRAM_ARB_RR_EN
        for (int i = 0; i < 4; i++) push_exp(i % 2, 1'b0, (i % 2 == 1) ? 32'h24 : 32'h20, 32'h0);
`else
        for (int i = 0; i < 4; i++) push_exp(0, 1'b0, 32'h20, 32'h0);
`endif
        n_done    = 0;
        p1_cycles = 0;
        for (int cyc = 0; cyc < 80 && n_done < 4; cyc++) begin
            @(negedge clk);
            if (owner == 2'b10) p1_cycles++;
            if (p0_done || p1_done) n_done++;
        end
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("contend_ops", n_done, 4);
`ifdef SRAM_ARB_RR_EN
        check_eq("contend_p1_cycles", p1_cycles, 14);
`else
        check_eq("contend_p1_cycles", p1_cycles, 0);
`endif
        @(negedge clk);
        check_eq("contend_idle", owner, 0);

        // p1 write with p0 arriving mid-BUSY and changing its address before being granted.
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h0000_0040, 32'h4040_4040);
        push_exp(1, 1'b1, 32'h40, 32'h4040_4040);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 2) drive(0, 1'b0, 1'b1, 32'h0000_0044, 32'h0);
            if (k == 3) begin
                p0_addr = 32'h0000_0048;
                push_exp(0, 1'b0, 32'h48, 32'h0);
            end
            @(negedge clk);
            check_eq("mid_addr", sram_address, 32'h40);
            check_eq("mid_owner", owner, 2'b10);
            check_eq("mid_p0_stall", p0_stall, k >= 2);
        end
        @(negedge clk);
        check_eq("mid_p1_done", p1_done, 1);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_eq("mid_idle", owner, 0);
        @(negedge clk);
        check_eq("mid_p0_owner", owner, 2'b01);
        check_eq("mid_p0_rden", sram_readEn, 1);
        check_eq("mid_p0_addr", sram_address, 32'h48);
        got = 1'b0;
        for (int cyc = 0; cyc < 12 && !got; cyc++) begin
            @(negedge clk);
            if (p0_done) got = 1'b1;
        end
        check_eq("mid_p0_done_seen", got, 1);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        check_eq("mid_p0_rdata", p0_rdata, 32'h4444_0004);

        // Reset during a read: no done pulse, rdata cleared.
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_pre_rden", sram_readEn, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_eq("abort_owner", owner, 0);
        check_eq("abort_rden", sram_readEn, 0);
        check_eq("abort_rdata", p0_rdata, 0);
        n_done = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk);
            if (p0_done || p1_done) n_done++;
        end
        check_eq("abort_no_done", n_done, 0);

        check_eq("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
